// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA timing path.
//   - Default 640x480@60 timing constants (pixels / lines).
//   - phase_t: the four phases every scan axis walks through.
//   - 12-bit RGB colour constants used by the pixel generators.
//   - next_phase(): successor of a phase in the ACTIVE->FRONT->SYNC->BACK ring.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

    localparam logic [11:0] COLOR_BLACK = 12'h000;
    localparam logic [11:0] COLOR_WHITE = 12'hFFF;
    localparam logic [11:0] COLOR_RED   = 12'hF00;
    localparam logic [11:0] COLOR_GREEN = 12'h0F0;
    localparam logic [11:0] COLOR_BLUE  = 12'h00F;

    function automatic phase_t next_phase(phase_t p);
        phase_t n;
        n = ACTIVE;
        case (p)
            ACTIVE:  n = FRONT;
            FRONT:   n = SYNC;
            SYNC:    n = BACK;
            default: n = ACTIVE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one scan axis (horizontal or vertical).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   advance     - step the axis by one position this cycle
//   clear       - return to position 0 / ACTIVE next cycle (used for recovery)
//   count       - absolute position within the axis, 0..total-1
//   phase       - current phase FSM state (also serves as the debug view)
//   wrap        - high in the cycle where an advance takes count from last to 0
//   fault       - phase, phase-local count and absolute count disagree
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int W_ACTIVE = DEF_H_ACTIVE,
    parameter int W_FRONT  = DEF_H_FRONT,
    parameter int W_SYNC   = DEF_H_SYNC,
    parameter int W_BACK   = DEF_H_BACK
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    input  logic       clear,
    output logic [9:0] count,
    output phase_t     phase,
    output logic       wrap,
    output logic       fault
);

    localparam logic [9:0] A_END = 10'(W_ACTIVE);
    localparam logic [9:0] F_END = 10'(W_ACTIVE + W_FRONT);
    localparam logic [9:0] S_END = 10'(W_ACTIVE + W_FRONT + W_SYNC);
    localparam logic [9:0] LAST  = 10'(W_ACTIVE + W_FRONT + W_SYNC + W_BACK - 1);

    logic [9:0] loc;        // position inside the current phase
    logic [9:0] base;       // absolute position where the current phase starts
    logic [9:0] span_last;  // last phase-local position of the current phase
    logic       in_range;

    // The phase is derived twice (FSM and absolute count); any disagreement
    // is flagged so the top can pull both axes back to a known point.
    always_comb begin
        base      = '0;
        span_last = '0;
        in_range  = 1'b0;
        case (phase)
            ACTIVE: begin
                base      = '0;
                span_last = 10'(W_ACTIVE - 1);
                in_range  = (count < A_END);
            end
            FRONT: begin
                base      = A_END;
                span_last = 10'(W_FRONT - 1);
                in_range  = (count >= A_END) && (count < F_END);
            end
            SYNC: begin
                base      = F_END;
                span_last = 10'(W_SYNC - 1);
                in_range  = (count >= F_END) && (count < S_END);
            end
            default: begin
                base      = S_END;
                span_last = 10'(W_BACK - 1);
                in_range  = (count >= S_END) && (count <= LAST);
            end
        endcase
        fault = !(in_range && (loc == count - base));
    end

    assign wrap = advance && !clear && !fault && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            loc   <= '0;
            phase <= ACTIVE;
        end else if (clear) begin
            count <= '0;
            loc   <= '0;
            phase <= ACTIVE;
        end else if (advance) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
            if (loc == span_last) begin
                loc   <= '0;
                phase <= next_phase(phase);
            end else begin
                loc <= loc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
// Ports:
//   clk, rst_n   - pixel clock, asynchronous active-low reset
//   col, row     - pixel position of the current output cycle
//   valid        - pixel is inside the visible area
//   hsync, vsync - active-low sync pulses
//   frame_start  - one-cycle pulse at (0,0)
//   line_end     - one-cycle pulse at the last column of every line
//   frame_count  - completed frames, modulo 256
// All outputs are registered copies of the axis state, so they lag the
// internal counters by one cycle and always describe the same pixel.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic       line_end,
    output logic [7:0] frame_count
);

    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);

    logic [9:0] h_count, v_count;
    phase_t     h_phase, v_phase;
    logic       h_wrap, v_wrap;
    logic       h_fault, v_fault;
    logic       clear;
    logic       last_pix_q;  // outputs currently show the last pixel of a frame

    // A fault on either axis restarts the whole raster.
    assign clear = h_fault | v_fault;

    vga_axis_counter #(
        .W_ACTIVE(H_ACTIVE), .W_FRONT(H_FRONT), .W_SYNC(H_SYNC), .W_BACK(H_BACK)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .advance(1'b1), .clear(clear),
        .count(h_count), .phase(h_phase), .wrap(h_wrap), .fault(h_fault)
    );

    vga_axis_counter #(
        .W_ACTIVE(V_ACTIVE), .W_FRONT(V_FRONT), .W_SYNC(V_SYNC), .W_BACK(V_BACK)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .advance(h_wrap), .clear(clear),
        .count(v_count), .phase(v_phase), .wrap(v_wrap), .fault(v_fault)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col         <= '0;
            row         <= '0;
            valid       <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
            frame_count <= '0;
            last_pix_q  <= 1'b0;
        end else begin
            col         <= h_count;
            row         <= v_count;
            valid       <= (h_phase == ACTIVE) && (v_phase == ACTIVE);
            hsync       <= (h_phase != SYNC);
            vsync       <= (v_phase != SYNC);
            frame_start <= (h_count == '0) && (v_count == '0);
            line_end    <= (h_count == H_LAST);
            // v_wrap registered lines up with the outputs showing the final
            // pixel; the count then steps on the same edge as frame_start.
            last_pix_q  <= v_wrap;
            if (last_pix_q) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one default-timing instance and one tiny-timing
// instance, both compared every cycle against an arithmetic raster model
// indexed by the number of clock edges since reset release.
module tb_vga_timing_gen;

    typedef struct {
        int col;
        int row;
        int valid;
        int hsync;
        int vsync;
        int fs;
        int le;
        int fc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n_def, rst_n_small;
    logic [9:0] d_col, d_row, s_col, s_row;
    logic       d_valid, d_hsync, d_vsync, d_fs, d_le;
    logic       s_valid, s_hsync, s_vsync, s_fs, s_le;
    logic [7:0] d_fc, s_fc;

    int n_vec = 0;
    int n_err = 0;
    int td, ts;          // edges since release for next sample; -1 = in reset
    int small_hold = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut_def (
        .clk(clk), .rst_n(rst_n_def), .col(d_col), .row(d_row), .valid(d_valid),
        .hsync(d_hsync), .vsync(d_vsync), .frame_start(d_fs), .line_end(d_le),
        .frame_count(d_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) dut_small (
        .clk(clk), .rst_n(rst_n_small), .col(s_col), .row(s_row), .valid(s_valid),
        .hsync(s_hsync), .vsync(s_vsync), .frame_start(s_fs), .line_end(s_le),
        .frame_count(s_fc)
    );

    // Raster model: position follows from the edge index by division.
    function automatic exp_t model(int t, int ha, int hf, int hs, int hb,
                                   int va, int vf, int vs, int vb);
        exp_t e;
        int ht, vt, c, r;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        if (t < 0) begin
            e = '{col: 0, row: 0, valid: 0, hsync: 1, vsync: 1, fs: 0, le: 0, fc: 0};
        end else begin
            c = t % ht;
            r = (t / ht) % vt;
            e.col   = c;
            e.row   = r;
            e.valid = (c < ha && r < va) ? 1 : 0;
            e.hsync = (c >= ha + hf && c < ha + hf + hs) ? 0 : 1;
            e.vsync = (r >= va + vf && r < va + vf + vs) ? 0 : 1;
            e.fs    = (c == 0 && r == 0) ? 1 : 0;
            e.le    = (c == ht - 1) ? 1 : 0;
            e.fc    = (t / (ht * vt)) % 256;
        end
        return e;
    endfunction

    task automatic check(string tag, int got, int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d (t_def=%0d t_small=%0d)",
                     tag, got, exp, td, ts);
        end
    endtask

    task automatic check_def();
        exp_t e;
        e = model(td, 640, 16, 96, 48, 480, 10, 2, 33);
        check("def.col",   int'(d_col),   e.col);
        check("def.row",   int'(d_row),   e.row);
        check("def.valid", int'(d_valid), e.valid);
        check("def.hsync", int'(d_hsync), e.hsync);
        check("def.vsync", int'(d_vsync), e.vsync);
        check("def.fs",    int'(d_fs),    e.fs);
        check("def.le",    int'(d_le),    e.le);
        check("def.fc",    int'(d_fc),    e.fc);
    endtask

    task automatic check_small();
        exp_t e;
        e = model(ts, 4, 1, 1, 1, 3, 1, 1, 1);
        check("small.col",   int'(s_col),   e.col);
        check("small.row",   int'(s_row),   e.row);
        check("small.valid", int'(s_valid), e.valid);
        check("small.hsync", int'(s_hsync), e.hsync);
        check("small.vsync", int'(s_vsync), e.vsync);
        check("small.fs",    int'(s_fs),    e.fs);
        check("small.le",    int'(s_le),    e.le);
        check("small.fc",    int'(s_fc),    e.fc);
    endtask

    // Sample on the falling edge, then advance the model indices.
    task automatic tick();
        @(negedge clk);
        check_def();
        check_small();
        if (td >= 0) td++;
        if (ts >= 0) ts++;
    endtask

    initial begin
        rst_n_def   = 1'b0;
        rst_n_small = 1'b0;
        td = -1;
        ts = -1;
        repeat (4) tick();

        // Release both; the next edge must show (0,0) with frame_start.
        rst_n_def   = 1'b1;
        rst_n_small = 1'b1;
        td = 0;
        ts = 0;

        // Default timing: run to col 300 of row 2 (edge index 1900).
        repeat (1901) tick();

        // Mid-line reset, checked before any further clock edge.
        rst_n_def = 1'b0;
        td = -1;
        #1;
        check_def();
        repeat (3) tick();
        rst_n_def = 1'b1;
        td = 0;

        // Tiny timing with random reset pulses.
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (small_hold > 0) begin
                small_hold--;
                if (small_hold == 0) begin
                    rst_n_small = 1'b1;
                    ts = 0;
                end
            end else if ($urandom_range(0, 99) == 0) begin
                rst_n_small = 1'b0;
                ts = -1;
                #1;
                check_small();
                small_hold = $urandom_range(1, 3);
            end
        end
        if (small_hold > 0) begin
            rst_n_small = 1'b1;
            ts = 0;
        end

        // Uninterrupted run past 256 tiny frames so frame_count wraps to 0.
        repeat (42 * 257 + 5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
